// File: rtl/mem_stage_lsu.sv
// Memory stage load/store unit: issues single-outstanding word-aligned data
// memory requests and presents a registered writeback result over valid/ready.
module mem_stage_lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] rs2_val_i,
    input  logic [2:0]      mem_op_i,
    input  logic            is_load_i,
    input  logic            is_store_i,
    input  logic [4:0]      rd_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] wb_data_o,
    output logic [4:0]      rd_o,
    output logic            fault_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_ack_i,
    input  logic [XLEN-1:0] dmem_rdata_i
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    logic [0:0]      state;
    logic [2:0]      p_op;
    logic [4:0]      p_rd;
    logic [1:0]      p_off;
    logic            p_load;

    logic [1:0]      off;
    logic            is_mem;
    logic            op_legal;
    logic            misaligned;
    logic            fault_in;
    logic            accept;
    logic [3:0]      be_in;
    logic [XLEN-1:0] wdata_in;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;

    assign in_ready_o = (state == IDLE) && (!out_valid_o || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign off        = alu_result_i[1:0];
    assign is_mem     = is_load_i || is_store_i;

    always_comb begin
        op_legal = 1'b0;
        if (is_store_i)
            op_legal = mem_op_i inside {3'b000, 3'b001, 3'b010};
        else
            op_legal = mem_op_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        misaligned = ((mem_op_i[1:0] == 2'b01) && off[0]) ||
                     ((mem_op_i[1:0] == 2'b10) && (off != 2'b00));
        fault_in   = is_mem && ((is_load_i && is_store_i) || !op_legal || misaligned);
    end

    always_comb begin
        be_in    = 4'b1111;
        wdata_in = rs2_val_i;
        case (mem_op_i[1:0])
            2'b00: begin
                be_in    = 4'b0001 << off;
                wdata_in = {4{rs2_val_i[7:0]}};
            end
            2'b01: begin
                be_in    = 4'b0011 << off;
                wdata_in = {2{rs2_val_i[15:0]}};
            end
            default: begin
                be_in    = 4'b1111;
                wdata_in = rs2_val_i;
            end
        endcase
    end

    always_comb begin
        shifted   = dmem_rdata_i >> {p_off, 3'b000};
        load_data = shifted;
        case (p_op)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            out_valid_o  <= 1'b0;
            wb_data_o    <= '0;
            rd_o         <= '0;
            fault_o      <= 1'b0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            p_op         <= '0;
            p_rd         <= '0;
            p_off        <= '0;
            p_load       <= 1'b0;
        end else begin
            // Drain first; a result loaded later on this same edge takes priority.
            if (out_valid_o && out_ready_i) begin
                out_valid_o <= 1'b0;
                wb_data_o   <= '0;
                rd_o        <= '0;
                fault_o     <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!is_mem) begin
                            out_valid_o <= 1'b1;
                            wb_data_o   <= alu_result_i;
                            rd_o        <= rd_i;
                            fault_o     <= 1'b0;
                        end else if (fault_in) begin
                            out_valid_o <= 1'b1;
                            wb_data_o   <= '0;
                            rd_o        <= '0;
                            fault_o     <= 1'b1;
                        end else begin
                            state        <= REQ;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= is_store_i;
                            dmem_addr_o  <= {alu_result_i[XLEN-1:2], 2'b00};
                            dmem_be_o    <= be_in;
                            dmem_wdata_o <= wdata_in;
                            p_op         <= mem_op_i;
                            p_rd         <= rd_i;
                            p_off        <= off;
                            p_load       <= is_load_i;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ack_i) begin
                        state       <= IDLE;
                        dmem_req_o  <= 1'b0;
                        dmem_we_o   <= 1'b0;
                        out_valid_o <= 1'b1;
                        wb_data_o   <= p_load ? load_data : '0;
                        rd_o        <= p_load ? p_rd : 5'd0;
                        fault_o     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] alu_result_i = '0;
    logic [31:0] rs2_val_i = '0;
    logic [2:0]  mem_op_i = '0;
    logic        is_load_i = 1'b0;
    logic        is_store_i = 1'b0;
    logic [4:0]  rd_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] wb_data_o;
    logic [4:0]  rd_o;
    logic        fault_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;

    int errors = 0;
    int checks = 0;

    mem_stage_lsu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .alu_result_i(alu_result_i), .rs2_val_i(rs2_val_i),
        .mem_op_i(mem_op_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
        .rd_i(rd_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .wb_data_o(wb_data_o), .rd_o(rd_o), .fault_o(fault_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  op;
        logic        load;
        logic [4:0]  rd;
    } tx_t;

    function automatic int size_of(input logic [2:0] op);
        if (op[1:0] == 2'b00) return 1;
        if (op[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // 0 = pass-through, 1 = fault, 2 = memory access
    function automatic int kind_of(input logic ld, input logic st, input logic [2:0] op,
                                   input logic [31:0] addr);
        int legal;
        if (!ld && !st) return 0;
        if (ld && st) return 1;
        if (st) legal = (op <= 3'd2) ? 1 : 0;
        else    legal = (op <= 3'd2 || op == 3'd4 || op == 3'd5) ? 1 : 0;
        if (legal == 0) return 1;
        if ((addr % size_of(op)) != 0) return 1;
        return 2;
    endfunction

    function automatic logic [3:0] exp_be(input tx_t t);
        logic [3:0] be;
        int o, s;
        o = int'(t.addr % 4);
        s = size_of(t.op);
        for (int i = 0; i < 4; i++) be[i] = (i >= o && i < o + s);
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input tx_t t);
        logic [31:0] w;
        int s;
        s = size_of(t.op);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = t.data[8*(i % s) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input tx_t t, input logic [31:0] rdata);
        logic [31:0] v;
        int o, s;
        o = int'(t.addr % 4);
        s = size_of(t.op);
        v = '0;
        for (int k = 0; k < s; k++) v[8*k +: 8] = rdata[8*(o + k) +: 8];
        if (s < 4 && !t.op[2] && v[8*s - 1]) v = v | ~((32'd1 << (8*s)) - 32'd1);
        return v;
    endfunction

    logic        m_pend;
    tx_t         m_tx;
    logic        m_ov;
    logic [31:0] m_wb;
    logic [4:0]  m_rd;
    logic        m_fault;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend = 1'b0; m_ov = 1'b0; m_wb = '0; m_rd = '0; m_fault = 1'b0;
            m_tx = '{addr: '0, data: '0, op: '0, load: 1'b0, rd: '0};
        end else begin
            logic acc;
            int   k;
            acc = in_valid_i && !m_pend && (!m_ov || out_ready_i);
            if (m_ov && out_ready_i) begin
                m_ov = 1'b0; m_wb = '0; m_rd = '0; m_fault = 1'b0;
            end
            if (m_pend && dmem_ack_i) begin
                m_pend = 1'b0; m_ov = 1'b1; m_fault = 1'b0;
                m_wb = m_tx.load ? exp_load(m_tx, dmem_rdata_i) : 32'd0;
                m_rd = m_tx.load ? m_tx.rd : 5'd0;
            end else if (acc) begin
                k = kind_of(is_load_i, is_store_i, mem_op_i, alu_result_i);
                if (k == 0) begin
                    m_ov = 1'b1; m_wb = alu_result_i; m_rd = rd_i; m_fault = 1'b0;
                end else if (k == 1) begin
                    m_ov = 1'b1; m_wb = '0; m_rd = '0; m_fault = 1'b1;
                end else begin
                    m_pend = 1'b1;
                    m_tx = '{addr: alu_result_i, data: rs2_val_i, op: mem_op_i,
                             load: is_load_i, rd: rd_i};
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready", 32'(in_ready_o), 32'(!m_pend && (!m_ov || out_ready_i)));
            chk("out_valid", 32'(out_valid_o), 32'(m_ov));
            if (m_ov) begin
                chk("wb_data", wb_data_o, m_wb);
                chk("rd", 32'(rd_o), 32'(m_rd));
                chk("fault", 32'(fault_o), 32'(m_fault));
            end
            chk("dmem_req", 32'(dmem_req_o), 32'(m_pend));
            if (m_pend) begin
                chk("dmem_we", 32'(dmem_we_o), 32'(!m_tx.load));
                chk("dmem_addr", dmem_addr_o, m_tx.addr & ~32'd3);
                chk("dmem_be", 32'(dmem_be_o), 32'(exp_be(m_tx)));
                chk("dmem_wdata", dmem_wdata_o, m_tx.load ? dmem_wdata_o : exp_wdata(m_tx));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
        in_valid_i = v; is_load_i = ld; is_store_i = st; mem_op_i = op;
        alu_result_i = a; rs2_val_i = d; rd_i = r;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid_o), 32'd0);
        chk("reset_req", 32'(dmem_req_o), 32'd0);
        chk("reset_wb", wb_data_o, 32'd0);
        chk("reset_be", 32'(dmem_be_o), 32'd0);
        rst = 1'b1;
        step();

        // pass-through
        drive(1, 0, 0, 3'b000, 32'h1234_5678, 32'h0, 5'd5);
        step();
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        chk("pt_valid", 32'(out_valid_o), 32'd1);
        chk("pt_wb", wb_data_o, 32'h1234_5678);
        chk("pt_rd", 32'(rd_o), 32'd5);
        chk("pt_req", 32'(dmem_req_o), 32'd0);
        step();

        // LB sign-extend, ack two cycles after request
        drive(1, 1, 0, 3'b000, 32'h0000_0103, 32'h0, 5'd7);
        step();
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        chk("lb_req", 32'(dmem_req_o), 32'd1);
        chk("lb_addr", dmem_addr_o, 32'h0000_0100);
        chk("lb_be", 32'(dmem_be_o), 32'b1000);
        step();
        step();
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h80FF_FF7F;
        step();
        dmem_ack_i = 1'b0;
        chk("lb_valid", 32'(out_valid_o), 32'd1);
        chk("lb_wb", wb_data_o, 32'hFFFF_FF80);
        chk("lb_rd", 32'(rd_o), 32'd7);
        chk("lb_req_drop", 32'(dmem_req_o), 32'd0);
        step();

        // SH lanes, ack on first request cycle
        drive(1, 0, 1, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 5'd9);
        dmem_ack_i = 1'b1;
        step();
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        chk("sh_be", 32'(dmem_be_o), 32'b1100);
        chk("sh_wdata", dmem_wdata_o, 32'hBEEF_BEEF);
        chk("sh_we", 32'(dmem_we_o), 32'd1);
        chk("sh_not_early", 32'(out_valid_o), 32'd0);
        step();
        dmem_ack_i = 1'b0;
        chk("sh_valid", 32'(out_valid_o), 32'd1);
        chk("sh_rd", 32'(rd_o), 32'd0);
        chk("sh_fault", 32'(fault_o), 32'd0);
        step();

        // misaligned LW
        drive(1, 1, 0, 3'b010, 32'h0000_0301, 32'h0, 5'd3);
        step();
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        chk("mis_req", 32'(dmem_req_o), 32'd0);
        chk("mis_fault", 32'(fault_o), 32'd1);
        chk("mis_valid", 32'(out_valid_o), 32'd1);
        chk("mis_wb", wb_data_o, 32'd0);
        chk("mis_rd", 32'(rd_o), 32'd0);
        step();

        // backpressure then back-to-back reload
        out_ready_i = 1'b0;
        drive(1, 0, 0, 3'b000, 32'hCAFE_0001, 32'h0, 5'd11);
        step();
        drive(1, 0, 0, 3'b000, 32'hCAFE_0002, 32'h0, 5'd12);
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready", 32'(in_ready_o), 32'd0);
            chk("bp_hold", wb_data_o, 32'hCAFE_0001);
            step();
        end
        out_ready_i = 1'b1;
        #1;
        chk("bp_ready_comb", 32'(in_ready_o), 32'd1);
        step();
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        chk("bp_next_valid", 32'(out_valid_o), 32'd1);
        chk("bp_next_wb", wb_data_o, 32'hCAFE_0002);
        step();

        // reset in the middle of an outstanding LW
        drive(1, 1, 0, 3'b010, 32'h0000_0400, 32'h0, 5'd4);
        step();
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        chk("rr_req", 32'(dmem_req_o), 32'd1);
        step();
        rst = 1'b0;
        #1;
        chk("rr_req_drop", 32'(dmem_req_o), 32'd0);
        step();
        rst = 1'b1;
        dmem_ack_i = 1'b1;
        step();
        dmem_ack_i = 1'b0;
        chk("rr_no_valid", 32'(out_valid_o), 32'd0);
        chk("rr_no_req", 32'(dmem_req_o), 32'd0);
        step();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int k;
            k = $urandom_range(0, 9);
            in_valid_i   = ($urandom_range(0, 99) < 60);
            is_load_i    = (k >= 4 && k <= 6) || k == 9;
            is_store_i   = (k >= 7);
            mem_op_i     = 3'($urandom_range(0, 7));
            alu_result_i = $urandom;
            rs2_val_i    = $urandom;
            rd_i         = 5'($urandom_range(0, 31));
            out_ready_i  = ($urandom_range(0, 99) < 70);
            dmem_ack_i   = ($urandom_range(0, 99) < 40);
            dmem_rdata_i = $urandom;
            step();
        end

        in_valid_i = 1'b0;
        dmem_ack_i = 1'b0;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Consumer end of the EX result path: takes the ALU result as a load/store address, or as a pass-through value, plus rs2 as store data.
- Issues word-aligned requests on a single-outstanding data-memory bus (req/ack).
- Aligns and sign-extends load data; presents a registered result to writeback over a valid/ready handshake.
- Sits between EX_Stage and the WB stage in the pipelined core.

Parameters:
- XLEN, 32, datapath and address width. Only 32 is supported.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  EX result valid
- in_ready_o  out  1  block can accept an EX result this cycle
- alu_result_i  in  32  address for load/store, writeback value otherwise
- rs2_val_i  in  32  store data
- mem_op_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- is_load_i  in  1  load instruction
- is_store_i  in  1  store instruction
- rd_i  in  5  destination register
- out_valid_o  out  1  writeback result valid
- out_ready_i  in  1  WB accepts the result
- wb_data_o  out  32  writeback value
- rd_o  out  5  destination register; forced to 0 for stores and faults
- fault_o  out  1  misaligned access or illegal op, qualified by out_valid_o
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  {addr[31:2],2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_ack_i  in  1  memory done; read data valid in the same cycle
- dmem_rdata_i  in  32  read data word

Behaviour:
- Reset (rst=0, immediate, asynchronous):
  - state = IDLE.
  - out_valid_o, dmem_req_o, dmem_we_o, fault_o = 0.
  - wb_data_o, rd_o, dmem_addr_o, dmem_be_o, dmem_wdata_o = 0.
- FSM states:
  - IDLE: waiting for a new EX result.
  - REQ: memory request outstanding.
- in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i). It is combinational from out_ready_i.
- Accept = in_valid_i && in_ready_o. Inputs are captured on the accepting edge (cycle N).
- Non-memory op (is_load_i=0, is_store_i=0):
  - At N+1: out_valid_o=1, wb_data_o=alu_result_i, rd_o=rd_i, fault_o=0.
  - Throughput is one per cycle while out_ready_i=1.
- Fault conditions:
  - is_load_i && is_store_i.
  - Illegal funct3: store with mem_op_i not in {000,001,010}; load with mem_op_i not in {000,001,010,100,101}.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
- On a fault:
  - No bus request is issued.
  - At N+1: out_valid_o=1, fault_o=1, wb_data_o=0, rd_o=0.
- Valid memory op:
  - At N+1: state=REQ and dmem_req_o=1, with addr, we, be and wdata registered.
  - All request fields stay stable while dmem_req_o=1.
  - dmem_ack_i is sampled every cycle dmem_req_o=1, including the first request cycle.
  - On an ack at edge M: dmem_req_o=0 at M+1, out_valid_o=1 at M+1, state returns to IDLE.
  - Minimum memory-op latency: 2 cycles from accept to out_valid_o.
  - dmem_ack_i is ignored when state != REQ.
- Byte enables (o = addr[1:0]):
  - B: 4'b0001<<o.
  - H: 4'b0011<<o.
  - W: 4'b1111.
- Store data lanes:
  - SB: {4{rs2[7:0]}}.
  - SH: {2{rs2[15:0]}}.
  - SW: rs2.
- Load data: rdata is shifted right by 8*o, then:
  - LB: sign-extend byte.
  - LBU: zero-extend byte.
  - LH: sign-extend halfword.
  - LHU: zero-extend halfword.
  - LW: word unchanged.
- Load result: wb_data_o = extended data, rd_o = rd_i.
- Store result: wb_data_o=0, rd_o=0, fault_o=0, reported on ack.
- Output hold: out_valid_o and all result fields hold until out_ready_i=1. They clear the cycle after acceptance unless a new result loads on the same edge.
- Simultaneous out-accept and in-accept in IDLE: the output register is overwritten with no bubble for a non-memory op.
- No new input is accepted while state=REQ, even if the output register is empty.
- Reset mid-REQ: dmem_req_o drops asynchronously and the transaction is abandoned. An ack arriving after reset release is ignored.

Test Plan:
- Pass-through: alu_result_i=0x1234_5678, rd_i=5, out_ready_i=1 -> one cycle later out_valid_o=1, wb_data_o=0x12345678, rd_o=5, dmem_req_o never asserts.
- LB sign-extend: addr 0x103, ack 2 cycles after req, rdata=0x80FF_FF7F -> dmem_addr_o=0x100, be=4'b1000, wb_data_o=0xFFFF_FF80, out_valid_o asserts the cycle after ack.
- SH lane: addr 0x202, rs2=0xAAAA_BEEF, ack on the first request cycle -> be=4'b1100, wdata=0xBEEF_BEEF, we=1, out_valid_o 2 cycles after accept with rd_o=0.
- Misaligned LW: addr 0x301 -> no dmem_req_o, out_valid_o=1 and fault_o=1 next cycle, wb_data_o=0, rd_o=0.
- Backpressure: out_ready_i=0 for 3 cycles after a pass-through result -> result stable, in_ready_o=0; on out_ready_i=1 with in_valid_i=1, the next result loads on the same edge with no gap.
- Reset mid-request: LW outstanding, then rst=0 for 1 cycle -> dmem_req_o=0 immediately; an ack arriving after reset release produces no out_valid_o.
